pr_dispatch_unit: RTL and testbench
===================================

Name: pr_dispatch_unit

Overview:
- Hardware consumer on the output side of the PR request FIFO. Pops pending {ou_id, grid_slot} requests itself, so software no longer drains the queue.
- Looks up each request in a software-programmed bitstream table, issues one DMA/ICAP load command, waits for completion and reports per-slot reconfiguration status to the RCA grid.
- Sits between the PR request FIFO and the PR DMA engine.

Parameters:
- NUM_SLOTS, 4, number of grid slots (GRID_NUM_COLS*GRID_NUM_ROWS)
- NUM_OUS, 8, number of operation units
- ADDR_W, 32, bitstream byte-address width
- LEN_W, 24, bitstream length width, in 32-bit words
- TIMEOUT_CYCLES, 1048576, WAIT_DONE watchdog limit (used only with PR_TIMEOUT_EN)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  FIFO non-empty (first-word fall-through)
- req_grid_slot  in  SLOT_W  head-entry slot
- req_ou_id  in  OU_W  head-entry OU
- req_pop  out  1  one-cycle FIFO pop
- tbl_we  in  1  table write strobe
- tbl_waddr  in  OU_W+SLOT_W  table index {ou_id, grid_slot}
- tbl_wdata  in  ADDR_W+LEN_W  {base_addr, len_words}
- cmd_valid  out  1  DMA command valid
- cmd_ready  in  1  DMA command accept
- cmd_addr  out  ADDR_W  bitstream base address
- cmd_len  out  LEN_W  bitstream length in words
- dma_done  in  1  single-cycle completion pulse
- dma_error  in  1  qualified by dma_done
- slot_busy  out  NUM_SLOTS  one-hot: slot under reconfiguration
- done_pulse  out  1  request finished, success or failure
- done_slot  out  SLOT_W  slot of the finished request
- done_ok  out  1  finished without error
- err_sticky  out  1  any failure since reset; cleared by err_clr
- err_clr  in  1  clears err_sticky

Behaviour:
- Reset (asynchronous, active-high): state=IDLE. req_pop, cmd_valid, done_pulse, done_ok and err_sticky are 0. slot_busy='0. cmd_addr, cmd_len and done_slot are '0. Table contents are not reset.
- Table:
  - NUM_OUS*NUM_SLOTS entries, indexed {ou_id, grid_slot}.
  - Synchronous write; registered read issued from IDLE.
  - Read-first: a same-cycle write to the index being read returns the old data.
- IDLE:
  - If req_valid, assert req_pop for 1 cycle, latch slot/ou, issue the table read and go to LOOKUP.
  - Requests are never popped outside IDLE.
- LOOKUP (1 cycle):
  - If len==0, the entry is unprogrammed: go to COMPLETE with ok=0.
  - Otherwise load cmd_addr/cmd_len, set slot_busy[slot] and go to ISSUE.
- ISSUE:
  - cmd_valid held high with stable addr/len until cmd_ready.
  - On the handshake cycle, drop cmd_valid and go to WAIT_DONE.
- WAIT_DONE:
  - On dma_done, go to COMPLETE with ok = !dma_error.
  - A dma_done pulse in any other state is ignored.
- COMPLETE (1 cycle):
  - done_pulse=1, done_slot=slot, done_ok=ok.
  - Clear slot_busy[slot]; if !ok, set err_sticky.
  - Return to IDLE.
- Throughput: minimum 5 cycles per request with cmd_ready=1 and dma_done arriving the cycle after the handshake. Back-to-back requests: the next pop occurs in the IDLE cycle following COMPLETE.
- err_sticky: a same-cycle err_clr and set resolves to set.
- Slot occupancy: at most one request in flight, so slot_busy is zero or one-hot.
- Duplicate requests for the same slot are serviced sequentially; each one reloads.

Optional Feature:
- PR_TIMEOUT_EN defined:
  - A 21-bit counter is cleared on entry to WAIT_DONE.
  - Reaching TIMEOUT_CYCLES forces COMPLETE with ok=0.
  - A dma_done pulse arriving later is ignored.
- PR_TIMEOUT_EN undefined: no counter; WAIT_DONE waits indefinitely.

Decomposition:
- rca_config package gains:
  - pr_bitstream_entry_t {base_addr, len_words}
  - pr_dispatch_state_t enum {IDLE, LOOKUP, ISSUE, WAIT_DONE, COMPLETE}
  - PR_TIMEOUT_CYCLES
  - SLOT_W and OU_W derived by $clog2 from NUM_SLOTS and NUM_OUS.
- Sub-module pr_bitstream_table: simple dual-port, registered-read, read-first RAM, inferable as LUTRAM/BRAM.

Test Plan:
1. Program entry {ou=2, slot=1} with base 0x0010_0000 and len 0x400; push the request with cmd_ready=1 and dma_done 3 cycles after the handshake. Expect:
   - 1 req_pop
   - cmd_addr=0x00100000, cmd_len=0x400
   - slot_busy=4'b0010 from LOOKUP+1 through COMPLETE
   - done_pulse with done_slot=1, done_ok=1.
2. Request an unprogrammed entry {ou=0, slot=3}. Expect no cmd_valid, done_ok=0 and err_sticky=1; err_clr then returns err_sticky to 0.
3. Hold cmd_ready=0 for 10 cycles. Expect cmd_valid high with addr/len stable throughout and no further req_pop.
4. Push 3 queued requests back-to-back. Expect exactly 3 pops, each in IDLE, and done_slot following FIFO order.
5. Return dma_done with dma_error=1. Expect done_ok=0, err_sticky=1 and slot_busy cleared.
6. With PR_TIMEOUT_EN and TIMEOUT_CYCLES=16, never send dma_done. Expect done_pulse with ok=0 at WAIT_DONE+16. Then assert rst mid-ISSUE and expect cmd_valid=0, slot_busy=0 and state=IDLE immediately.

Source files
------------

// File: rtl/pr_dispatch_unit_pkg.sv
// -----------------------------------------------------------------------------
// pr_dispatch_unit_pkg
//   Shared types and constants for the partial-reconfiguration dispatch unit:
//   bitstream table entry layout, dispatch FSM state encoding, default sizes
//   and the WAIT_DONE watchdog limit.
//   Optional feature macro used by the dispatch unit: PR_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package pr_dispatch_unit_pkg;

   localparam int PR_NUM_SLOTS      = 4;        // GRID_NUM_COLS*GRID_NUM_ROWS
   localparam int PR_NUM_OUS        = 8;
   localparam int PR_ADDR_W         = 32;       // bitstream byte address
   localparam int PR_LEN_W          = 24;       // bitstream length, 32-bit words
   localparam int PR_TIMEOUT_CYCLES = 1048576;  // WAIT_DONE watchdog limit
   localparam int PR_TMO_CNT_W      = 21;

   localparam int SLOT_W = $clog2(PR_NUM_SLOTS);
   localparam int OU_W   = $clog2(PR_NUM_OUS);

   typedef struct packed {
      logic [PR_ADDR_W-1:0] base_addr;
      logic [PR_LEN_W-1:0]  len_words;
   } pr_bitstream_entry_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOOKUP    = 3'd1,
      ISSUE     = 3'd2,
      WAIT_DONE = 3'd3,
      COMPLETE  = 3'd4
   } pr_dispatch_state_t;

endpackage

// File: rtl/pr_dispatch_unit_bitstream_table.sv
// -----------------------------------------------------------------------------
// pr_bitstream_table
//   Simple dual-port RAM holding one {base_addr, len_words} entry per
//   {ou_id, grid_slot}. Synchronous write, registered read with read enable,
//   read-first on a same-cycle write to the read index. No reset on the array
//   or the read register so it maps onto LUTRAM/BRAM.
// Ports:
//   clk_i            clock
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i     read request (data appears on rdata_o the next cycle)
//   rdata_o          registered read data
// -----------------------------------------------------------------------------
module pr_bitstream_table #(
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int DW    = 56
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   // Both ports in one process: the read samples the array before the write
   // lands, which gives read-first behaviour on an address collision.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/pr_dispatch_unit.sv
// -----------------------------------------------------------------------------
// pr_dispatch_unit
//   Drains the PR request FIFO in hardware. Each {ou_id, grid_slot} request is
//   looked up in a software-programmed bitstream table, turned into one DMA /
//   ICAP load command, and its completion is reported per slot to the grid.
//   One request is in flight at a time.
//
//   Optional feature: `define PR_TIMEOUT_EN adds a WAIT_DONE watchdog that
//   forces a failed completion after TIMEOUT_CYCLES cycles without dma_done.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_grid_slot/req_ou_id/req_pop   FWFT request FIFO head + pop
//   tbl_we/tbl_waddr/tbl_wdata    table write port, index {ou_id, grid_slot}
//   cmd_valid/cmd_ready/cmd_addr/cmd_len        DMA command
//   dma_done/dma_error            completion pulse, error qualified by done
//   slot_busy                     one-hot slot under reconfiguration
//   done_pulse/done_slot/done_ok  per-request completion report
//   err_sticky/err_clr            sticky failure flag and its clear
//   dbg_state                     current dispatch FSM state
//
// Handshake: cmd_valid rises with cmd_addr/cmd_len loaded and both stay
// constant until a cycle in which cmd_valid && cmd_ready; that cycle is the
// transfer, after which cmd_valid drops. cmd_valid never depends on cmd_ready.
// -----------------------------------------------------------------------------
module pr_dispatch_unit
   import pr_dispatch_unit_pkg::*;
#(
   parameter int NUM_SLOTS      = PR_NUM_SLOTS,
   parameter int NUM_OUS        = PR_NUM_OUS,
   parameter int ADDR_W         = PR_ADDR_W,
   parameter int LEN_W          = PR_LEN_W,
   parameter int TIMEOUT_CYCLES = PR_TIMEOUT_CYCLES
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       req_valid,
   input  logic [$clog2(NUM_SLOTS)-1:0]               req_grid_slot,
   input  logic [$clog2(NUM_OUS)-1:0]                 req_ou_id,
   output logic                                       req_pop,
   input  logic                                       tbl_we,
   input  logic [$clog2(NUM_OUS)+$clog2(NUM_SLOTS)-1:0] tbl_waddr,
   input  logic [ADDR_W+LEN_W-1:0]                    tbl_wdata,
   output logic                                       cmd_valid,
   input  logic                                       cmd_ready,
   output logic [ADDR_W-1:0]                          cmd_addr,
   output logic [LEN_W-1:0]                           cmd_len,
   input  logic                                       dma_done,
   input  logic                                       dma_error,
   output logic [NUM_SLOTS-1:0]                       slot_busy,
   output logic                                       done_pulse,
   output logic [$clog2(NUM_SLOTS)-1:0]               done_slot,
   output logic                                       done_ok,
   output logic                                       err_sticky,
   input  logic                                       err_clr,
   output logic [2:0]                                 dbg_state
);

   localparam int SLOT_BITS = $clog2(NUM_SLOTS);
   localparam int OU_BITS   = $clog2(NUM_OUS);
   localparam int IDX_BITS  = SLOT_BITS + OU_BITS;
   localparam int ENTRY_W   = ADDR_W + LEN_W;

   pr_dispatch_state_t     state_q;
   logic [SLOT_BITS-1:0]   slot_q;
   logic                   cmd_valid_q;
   logic [ADDR_W-1:0]      cmd_addr_q;
   logic [LEN_W-1:0]       cmd_len_q;
   logic [NUM_SLOTS-1:0]   slot_busy_q;
   logic                   done_pulse_q;
   logic [SLOT_BITS-1:0]   done_slot_q;
   logic                   done_ok_q;
   logic                   err_sticky_q;

   logic                   tbl_re;
   logic [ENTRY_W-1:0]     tbl_rdata;
   logic [ADDR_W-1:0]      rd_addr;
   logic [LEN_W-1:0]       rd_len;

   // The pop has to coincide with the IDLE cycle that accepts the head entry,
   // so it is decoded from the state rather than registered. It is held off
   // during reset so the FIFO cannot drain while the FSM is frozen.
   assign req_pop = (state_q == IDLE) && req_valid && !rst;

   // The table is read with the live FIFO head; the data is valid in LOOKUP,
   // so the OU id never needs its own register.
   assign tbl_re = (state_q == IDLE) && req_valid;

   pr_bitstream_table #(
      .DEPTH (NUM_OUS * NUM_SLOTS),
      .AW    (IDX_BITS),
      .DW    (ENTRY_W)
   ) u_table (
      .clk_i   (clk),
      .we_i    (tbl_we),
      .waddr_i (tbl_waddr),
      .wdata_i (tbl_wdata),
      .re_i    (tbl_re),
      .raddr_i ({req_ou_id, req_grid_slot}),
      .rdata_o (tbl_rdata)
   );

   assign rd_addr = tbl_rdata[ENTRY_W-1:LEN_W];
   assign rd_len  = tbl_rdata[LEN_W-1:0];

`ifdef PR_TIMEOUT_EN
   localparam logic [PR_TMO_CNT_W-1:0] TMO_LAST = PR_TMO_CNT_W'(TIMEOUT_CYCLES - 1);
   logic [PR_TMO_CNT_W-1:0] tmo_cnt_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         slot_q       <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_len_q    <= '0;
         slot_busy_q  <= '0;
         done_pulse_q <= 1'b0;
         done_slot_q  <= '0;
         done_ok_q    <= 1'b0;
         err_sticky_q <= 1'b0;
`ifdef PR_TIMEOUT_EN
         tmo_cnt_q    <= '0;
`endif
      end else begin
         done_pulse_q <= 1'b0;
         // A set in COMPLETE below comes later in the block and wins over a
         // same-cycle clear.
         if (err_clr) begin
            err_sticky_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  slot_q  <= req_grid_slot;
                  state_q <= LOOKUP;
               end
            end

            LOOKUP: begin
               // Zero length marks an entry software never programmed.
               if (rd_len == '0) begin
                  done_pulse_q <= 1'b1;
                  done_slot_q  <= slot_q;
                  done_ok_q    <= 1'b0;
                  state_q      <= COMPLETE;
               end else begin
                  cmd_addr_q  <= rd_addr;
                  cmd_len_q   <= rd_len;
                  cmd_valid_q <= 1'b1;
                  slot_busy_q <= NUM_SLOTS'(1) << slot_q;
                  state_q     <= ISSUE;
               end
            end

            ISSUE: begin
               if (cmd_ready) begin
                  cmd_valid_q <= 1'b0;
                  state_q     <= WAIT_DONE;
`ifdef PR_TIMEOUT_EN
                  tmo_cnt_q   <= '0;
`endif
               end
            end

            WAIT_DONE: begin
               if (dma_done) begin
                  done_pulse_q <= 1'b1;
                  done_slot_q  <= slot_q;
                  done_ok_q    <= !dma_error;
                  state_q      <= COMPLETE;
`ifdef PR_TIMEOUT_EN
               end else if (tmo_cnt_q == TMO_LAST) begin
                  // Watchdog expiry: report failure; a late dma_done then
                  // lands outside WAIT_DONE and is dropped.
                  done_pulse_q <= 1'b1;
                  done_slot_q  <= slot_q;
                  done_ok_q    <= 1'b0;
                  state_q      <= COMPLETE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
               end
            end

            COMPLETE: begin
               slot_busy_q <= '0;
               if (!done_ok_q) begin
                  err_sticky_q <= 1'b1;
               end
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cmd_valid  = cmd_valid_q;
   assign cmd_addr   = cmd_addr_q;
   assign cmd_len    = cmd_len_q;
   assign slot_busy  = slot_busy_q;
   assign done_pulse = done_pulse_q;
   assign done_slot  = done_slot_q;
   assign done_ok    = done_ok_q;
   assign err_sticky = err_sticky_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_pr_dispatch_unit.sv
// -----------------------------------------------------------------------------
// tb_pr_dispatch_unit
//   Directed bench for pr_dispatch_unit: a queue models the FWFT request FIFO,
//   DMA responses are driven by hand, and every expected value is written out
//   explicitly. Define PR_TIMEOUT_EN to include the watchdog step.
// -----------------------------------------------------------------------------
module tb_pr_dispatch_unit;
   import pr_dispatch_unit_pkg::*;

   localparam int TB_TIMEOUT = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle++;

   // ---------------- DUT signals ----------------
   logic                     req_valid = 1'b0;
   logic [SLOT_W-1:0]        req_grid_slot = '0;
   logic [OU_W-1:0]          req_ou_id = '0;
   logic                     req_pop;
   logic                     tbl_we = 1'b0;
   logic [OU_W+SLOT_W-1:0]   tbl_waddr = '0;
   logic [PR_ADDR_W+PR_LEN_W-1:0] tbl_wdata = '0;
   logic                     cmd_valid;
   logic                     cmd_ready = 1'b0;
   logic [PR_ADDR_W-1:0]     cmd_addr;
   logic [PR_LEN_W-1:0]      cmd_len;
   logic                     dma_done = 1'b0;
   logic                     dma_error = 1'b0;
   logic [PR_NUM_SLOTS-1:0]  slot_busy;
   logic                     done_pulse;
   logic [SLOT_W-1:0]        done_slot;
   logic                     done_ok;
   logic                     err_sticky;
   logic                     err_clr = 1'b0;
   logic [2:0]               dbg_state;

   pr_dispatch_unit #(
      .NUM_SLOTS      (PR_NUM_SLOTS),
      .NUM_OUS        (PR_NUM_OUS),
      .ADDR_W         (PR_ADDR_W),
      .LEN_W          (PR_LEN_W),
      .TIMEOUT_CYCLES (TB_TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_grid_slot (req_grid_slot),
      .req_ou_id     (req_ou_id),
      .req_pop       (req_pop),
      .tbl_we        (tbl_we),
      .tbl_waddr     (tbl_waddr),
      .tbl_wdata     (tbl_wdata),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_addr      (cmd_addr),
      .cmd_len       (cmd_len),
      .dma_done      (dma_done),
      .dma_error     (dma_error),
      .slot_busy     (slot_busy),
      .done_pulse    (done_pulse),
      .done_slot     (done_slot),
      .done_ok       (done_ok),
      .err_sticky    (err_sticky),
      .err_clr       (err_clr),
      .dbg_state     (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   int pop_cnt = 0;
   logic [OU_W+SLOT_W-1:0] fifo_q[$];
   logic [SLOT_W-1:0]      exp_q[$];
   logic [SLOT_W-1:0]      done_slot_log[$];
   logic                   done_ok_log[$];
   int                     done_cyc_log[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic fifo_refresh();
      if (fifo_q.size() > 0) begin
         req_valid = 1'b1;
         {req_ou_id, req_grid_slot} = fifo_q[0];
      end else begin
         req_valid = 1'b0;
      end
   endtask

   task automatic push_req(input int ou, input int slot);
      fifo_q.push_back({OU_W'(ou), SLOT_W'(slot)});
      fifo_refresh();
   endtask

   task automatic tbl_write(input int idx, input logic [31:0] base, input logic [23:0] len);
      pr_bitstream_entry_t e;
      e.base_addr = base;
      e.len_words = len;
      tbl_we    = 1'b1;
      tbl_waddr = (OU_W + SLOT_W)'(idx);
      tbl_wdata = e;
      tick();
      tbl_we    = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] s, input int max_cycles, input string tag);
      int n = 0;
      while (dbg_state !== s && n < max_cycles) begin
         tick();
         n++;
      end
      check(tag, dbg_state, s);
   endtask

   // ---------------- FIFO model: pop on the edge where req_pop is seen ----------------
   always @(posedge clk) begin
      if (req_pop === 1'b1) begin
         pop_cnt++;
         check("pop_in_idle", dbg_state, IDLE);
         #1;
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         fifo_refresh();
      end
   end

   // ---------------- completion monitor ----------------
   always @(negedge clk) begin
      if (done_pulse === 1'b1) begin
         done_slot_log.push_back(done_slot);
         done_ok_log.push_back(done_ok);
         done_cyc_log.push_back(cycle);
      end
   end

   // ---------------- global watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, checks=%0d errors=%0d", checks, errors + 1);
      $fatal(1, "bench watchdog expired");
   end

   // ---------------- directed sequence ----------------
   logic [31:0] exp_addr [3] = '{32'h2000_0000, 32'h3000_0000, 32'h0010_0000};
   int p0;

   initial begin
      // Reset state
      tick(2);
      check("rst_state",      dbg_state,  IDLE);
      check("rst_req_pop",    req_pop,    1'b0);
      check("rst_cmd_valid",  cmd_valid,  1'b0);
      check("rst_done_pulse", done_pulse, 1'b0);
      check("rst_done_ok",    done_ok,    1'b0);
      check("rst_err_sticky", err_sticky, 1'b0);
      check("rst_slot_busy",  slot_busy,  4'b0000);
      check("rst_cmd_addr",   cmd_addr,   32'h0);
      check("rst_cmd_len",    cmd_len,    24'h0);
      check("rst_done_slot",  done_slot,  2'd0);
      rst = 1'b0;
      tick();

      // Software initialises the table: all unprogrammed, then three entries.
      for (int i = 0; i < PR_NUM_OUS * PR_NUM_SLOTS; i++) tbl_write(i, 32'h0, 24'h0);
      tbl_write(2 * 4 + 1, 32'h0010_0000, 24'h000400);  // {ou=2, slot=1}
      tbl_write(1 * 4 + 0, 32'h2000_0000, 24'h000010);  // {ou=1, slot=0}
      tbl_write(3 * 4 + 2, 32'h3000_0000, 24'h000020);  // {ou=3, slot=2}

      // 1: programmed request, dma_done three cycles after the handshake
      cmd_ready = 1'b1;
      p0 = pop_cnt;
      push_req(2, 1);
      tick();
      check("t1_lookup",      dbg_state, LOOKUP);
      check("t1_pop_once",    pop_cnt,   p0 + 1);
      check("t1_busy_lookup", slot_busy, 4'b0000);
      tick();
      check("t1_issue",       dbg_state, ISSUE);
      check("t1_cmd_valid",   cmd_valid, 1'b1);
      check("t1_cmd_addr",    cmd_addr,  32'h0010_0000);
      check("t1_cmd_len",     cmd_len,   24'h000400);
      check("t1_busy_issue",  slot_busy, 4'b0010);
      tick();
      check("t1_wait",        dbg_state, WAIT_DONE);
      check("t1_cmd_dropped", cmd_valid, 1'b0);
      check("t1_busy_wait",   slot_busy, 4'b0010);
      tick();
      dma_done = 1'b1;
      tick();
      dma_done = 1'b0;
      check("t1_complete",    dbg_state,  COMPLETE);
      check("t1_done_pulse",  done_pulse, 1'b1);
      check("t1_done_slot",   done_slot,  2'd1);
      check("t1_done_ok",     done_ok,    1'b1);
      check("t1_busy_cmpl",   slot_busy,  4'b0010);
      tick();
      check("t1_idle",        dbg_state,  IDLE);
      check("t1_pulse_once",  done_pulse, 1'b0);
      check("t1_busy_clear",  slot_busy,  4'b0000);
      check("t1_no_err",      err_sticky, 1'b0);

      // 2: unprogrammed entry {ou=0, slot=3}
      push_req(0, 3);
      tick();
      check("t2_lookup",      dbg_state,  LOOKUP);
      tick();
      check("t2_complete",    dbg_state,  COMPLETE);
      check("t2_done_pulse",  done_pulse, 1'b1);
      check("t2_done_slot",   done_slot,  2'd3);
      check("t2_done_ok",     done_ok,    1'b0);
      check("t2_no_cmd",      cmd_valid,  1'b0);
      check("t2_no_busy",     slot_busy,  4'b0000);
      tick();
      check("t2_err_set",     err_sticky, 1'b1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("t2_err_clr",     err_sticky, 1'b0);

      // 3: stalled command, second request queued behind; stray dma_done in ISSUE
      cmd_ready = 1'b0;
      p0 = pop_cnt;
      push_req(2, 1);
      push_req(0, 3);
      tick(2);
      for (int i = 0; i < 10; i++) begin
         check("t3_state_hold", dbg_state, ISSUE);
         check("t3_valid_hold", cmd_valid, 1'b1);
         check("t3_addr_hold",  cmd_addr,  32'h0010_0000);
         check("t3_len_hold",   cmd_len,   24'h000400);
         dma_done = (i == 3);
         tick();
      end
      dma_done = 1'b0;
      check("t3_single_pop", pop_cnt, p0 + 1);
      cmd_ready = 1'b1;
      tick();
      check("t3_wait",       dbg_state, WAIT_DONE);
      check("t3_valid_drop", cmd_valid, 1'b0);
      dma_done = 1'b1;
      tick();
      dma_done = 1'b0;
      check("t3_done_ok",    done_ok,   1'b1);
      check("t3_done_slot",  done_slot, 2'd1);
      tick(3);
      check("t3b_done_pulse", done_pulse, 1'b1);
      check("t3b_done_slot",  done_slot,  2'd3);
      check("t3b_done_ok",    done_ok,    1'b0);
      tick();
      check("t3b_err",        err_sticky, 1'b1);
      check("t3_two_pops",    pop_cnt,    p0 + 2);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;

      // 4: three queued requests, fastest DMA response
      done_slot_log.delete();
      done_ok_log.delete();
      done_cyc_log.delete();
      p0 = pop_cnt;
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd1);
      push_req(1, 0);
      push_req(3, 2);
      push_req(2, 1);
      for (int i = 0; i < 3; i++) begin
         wait_state(WAIT_DONE, 20, "t4_reach_wait");
         check("t4_cmd_addr", cmd_addr, exp_addr[i]);
         dma_done = 1'b1;
         tick();
         dma_done = 1'b0;
      end
      tick(2);
      check("t4_three_pops", pop_cnt, p0 + 3);
      check("t4_done_count", done_slot_log.size(), 3);
      for (int i = 0; i < 3; i++) begin
         logic [SLOT_W-1:0] e;
         e = exp_q.pop_front();
         check("t4_fifo_order", (i < done_slot_log.size()) ? done_slot_log[i] : 'x, e);
         check("t4_done_ok",    (i < done_ok_log.size())   ? done_ok_log[i]   : 'x, 1'b1);
      end
      for (int i = 1; i < 3; i++) begin
         check("t4_5_cycle_rate",
               (i < done_cyc_log.size()) ? done_cyc_log[i] - done_cyc_log[i-1] : -1, 5);
      end

      // 5: DMA error; err_clr in the same cycle as the set
      push_req(2, 1);
      wait_state(WAIT_DONE, 10, "t5_reach_wait");
      dma_done  = 1'b1;
      dma_error = 1'b1;
      tick();
      dma_done  = 1'b0;
      dma_error = 1'b0;
      check("t5_complete",   dbg_state,  COMPLETE);
      check("t5_done_pulse", done_pulse, 1'b1);
      check("t5_done_ok",    done_ok,    1'b0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("t5_busy_clear", slot_busy,  4'b0000);
      check("t5_set_wins",   err_sticky, 1'b1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("t5_err_clr",    err_sticky, 1'b0);
      dma_done = 1'b1;   // stray completion while idle
      tick();
      dma_done = 1'b0;
      tick();
      check("t5_idle_ignore", done_pulse, 1'b0);
      check("t5_idle_state",  dbg_state,  IDLE);

`ifdef PR_TIMEOUT_EN
      // 6a: watchdog, no dma_done at all
      begin
         int n;
         push_req(2, 1);
         wait_state(WAIT_DONE, 10, "t6_reach_wait");
         n = 0;
         while (done_pulse !== 1'b1 && n < 40) begin
            tick();
            n++;
         end
         check("t6_timeout_at", n, TB_TIMEOUT);
         check("t6_done_ok",    done_ok, 1'b0);
         tick();
         check("t6_err",        err_sticky, 1'b1);
         dma_done = 1'b1;   // late completion
         tick();
         dma_done = 1'b0;
         check("t6_late_ignored", done_pulse, 1'b0);
         err_clr = 1'b1;
         tick();
         err_clr = 1'b0;
      end
`endif

      // 6b: asynchronous reset in the middle of ISSUE
      cmd_ready = 1'b0;
      push_req(2, 1);
      wait_state(ISSUE, 10, "t6_reach_issue");
      check("t6_pre_rst_valid", cmd_valid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_cmd_valid", cmd_valid, 1'b0);
      check("t6_rst_busy",      slot_busy, 4'b0000);
      check("t6_rst_state",     dbg_state, IDLE);
      tick();
      rst = 1'b0;
      cmd_ready = 1'b1;
      tick();
      check("t6_post_rst_idle", dbg_state, IDLE);
      check("t6_post_rst_cmd",  cmd_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
